// File: rtl/ifu_prefetch.sv
// ifu_prefetch: fetches aligned 64-bit beats over req/gnt/rvalid, splits them
// into 32-bit instructions and queues {pc, ins} for decode.
// Ports: i_clk, i_rst (async, active high); i_redirect/i_redirect_pc restart
// fetch; o_mem_req/o_mem_addr/i_mem_gnt/i_mem_rvalid/i_mem_rdata memory port;
// o_ins_valid/o_ins/o_pc/i_ins_ready decode handshake.
module ifu_prefetch #(
  parameter int CPU_WIDTH = 64,
  parameter int INS_WIDTH = 32,
  parameter int MEM_WIDTH = 64,
  parameter int FIFO_DEPTH = 4,
  parameter logic [CPU_WIDTH-1:0] PC_START = 64'h8000_0000
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_redirect,
  input  logic [CPU_WIDTH-1:0] i_redirect_pc,
  output logic                 o_mem_req,
  output logic [CPU_WIDTH-1:0] o_mem_addr,
  input  logic                 i_mem_gnt,
  input  logic                 i_mem_rvalid,
  input  logic [MEM_WIDTH-1:0] i_mem_rdata,
  output logic                 o_ins_valid,
  output logic [INS_WIDTH-1:0] o_ins,
  output logic [CPU_WIDTH-1:0] o_pc,
  input  logic                 i_ins_ready
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH = CW'(FIFO_DEPTH);
  localparam logic [CPU_WIDTH-1:0] BEAT_MASK = ~CPU_WIDTH'(7);
  localparam logic [CPU_WIDTH-1:0] WORD_MASK = ~CPU_WIDTH'(3);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  state_t state, state_n;

  logic [CPU_WIDTH-1:0] fetch_pc;
  logic [CPU_WIDTH-1:0] req_addr;
  logic                 drop;
  logic [AW-1:0]        rd_ptr;
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        wr_ptr1;
  logic [CW-1:0]        count;

  logic [INS_WIDTH-1:0] ins_q [FIFO_DEPTH];
  logic [CPU_WIDTH-1:0] pc_q  [FIFO_DEPTH];

  logic                 beat_ok;
  logic                 upper_only;
  logic [1:0]           push_n;
  logic                 pop;
  logic                 space;
  logic [CPU_WIDTH-1:0] redir_pc;
  logic [INS_WIDTH-1:0] lo_ins;
  logic [INS_WIDTH-1:0] hi_ins;

  assign redir_pc   = i_redirect_pc & WORD_MASK;
  assign lo_ins     = i_mem_rdata[INS_WIDTH-1:0];
  assign hi_ins     = i_mem_rdata[MEM_WIDTH-1:INS_WIDTH];
  assign upper_only = fetch_pc[2];
  assign wr_ptr1    = wr_ptr + AW'(1);

  // A beat is kept only when it answers a live request and no redirect
  // arrives with it.
  assign beat_ok = (state == WAIT) & i_mem_rvalid & ~drop & ~i_redirect;
  assign push_n  = beat_ok ? (upper_only ? 2'd1 : 2'd2) : 2'd0;
  assign pop     = o_ins_valid & i_ins_ready & ~i_redirect;
  assign space   = count <= (DEPTH - CW'(2));

  assign o_ins_valid = count != '0;
  assign o_ins       = o_ins_valid ? ins_q[rd_ptr] : '0;
  assign o_pc        = o_ins_valid ? pc_q[rd_ptr] : '0;
  assign o_mem_addr  = req_addr;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n   = state;
    o_mem_req = 1'b0;
    unique case (state)
      IDLE: if (space && !i_redirect) state_n = REQ;
      REQ: begin
        o_mem_req = 1'b1;
        if (i_mem_gnt) state_n = WAIT;
      end
      WAIT: if (i_mem_rvalid) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      fetch_pc <= PC_START;
      req_addr <= PC_START & BEAT_MASK;
      drop     <= 1'b0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else begin
      // Latched so the address holds even if a redirect lands in REQ.
      if (state == IDLE && state_n == REQ)
        req_addr <= fetch_pc & BEAT_MASK;
      if (i_redirect) begin
        fetch_pc <= redir_pc;
        rd_ptr   <= '0;
        wr_ptr   <= '0;
        count    <= '0;
      end else begin
        if (beat_ok)
          fetch_pc <= fetch_pc +
                      (upper_only ? CPU_WIDTH'(4) : CPU_WIDTH'(8));
        wr_ptr <= wr_ptr + AW'(push_n);
        rd_ptr <= rd_ptr + AW'(pop);
        count  <= count + CW'(push_n) - CW'(pop);
      end
      // The in-flight response consumes the drop, even with a new redirect.
      if (state == WAIT && i_mem_rvalid)
        drop <= 1'b0;
      else if (i_redirect && state != IDLE)
        drop <= 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (beat_ok) begin
      pc_q[wr_ptr] <= fetch_pc;
      if (upper_only) begin
        ins_q[wr_ptr] <= hi_ins;
      end else begin
        ins_q[wr_ptr]  <= lo_ins;
        ins_q[wr_ptr1] <= hi_ins;
        pc_q[wr_ptr1]  <= fetch_pc + CPU_WIDTH'(4);
      end
    end
  end

  a_count: assert property (
    @(posedge i_clk) disable iff (i_rst) count <= DEPTH);

endmodule

// File: doc/ifu_prefetch.md
Name: ifu_prefetch

Overview:
- Parametrised successor to the single-cycle fetch unit.
- Fetches aligned MEM_WIDTH-bit beats from a variable-latency memory read port using a req/gnt/rvalid handshake.
- Splits each beat into INS_WIDTH-bit instructions and queues them, with their PCs, in a FIFO_DEPTH-entry prefetch buffer.
- Sits between the memory port and decode; decode pops through a valid/ready handshake and redirects fetch on branches or traps.

Parameters:
- CPU_WIDTH, 64, PC and address width.
- INS_WIDTH, 32, instruction width.
- MEM_WIDTH, 64, memory beat width. Fixed at 2*INS_WIDTH.
- FIFO_DEPTH, 4, prefetch buffer entries. Power of two, at least 2.
- PC_START, 64'h8000_0000, fetch PC after reset.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  asynchronous, active-high reset.
- i_redirect  in  1  flush the buffer and restart fetch at i_redirect_pc.
- i_redirect_pc  in  CPU_WIDTH  new fetch PC. Bits [1:0] are ignored.
- o_mem_req  out  1  read request.
- o_mem_addr  out  CPU_WIDTH  beat-aligned address, {fetch_pc[CPU_WIDTH-1:3],3'b0}.
- i_mem_gnt  in  1  request accepted this cycle.
- i_mem_rvalid  in  1  read data valid.
- i_mem_rdata  in  MEM_WIDTH  read beat.
- o_ins_valid  out  1  buffer head is valid.
- o_ins  out  INS_WIDTH  instruction at the buffer head.
- o_pc  out  CPU_WIDTH  PC of o_ins.
- i_ins_ready  in  1  decode accepts the head.

Behaviour:
- Reset (asynchronous, active-high):
  - fetch_pc = PC_START, state IDLE, buffer empty, drop = 0.
  - o_mem_req = 0, o_ins_valid = 0, o_ins = 0, o_pc = 0.
- State machine IDLE -> REQ -> WAIT -> IDLE:
  - IDLE: move to REQ when free entries >= 2 and i_redirect = 0.
  - REQ: o_mem_req = 1. o_mem_addr stays stable until i_mem_gnt. On i_mem_gnt, move to WAIT.
  - WAIT: o_mem_req = 0. On i_mem_rvalid, push the beat (unless drop) and move to IDLE.
- At most one request is outstanding. i_mem_rvalid never arrives in the same cycle as its gnt. i_mem_rvalid outside WAIT is ignored.
- Beat split:
  - If fetch_pc[2] = 0: push {fetch_pc, rdata[31:0]}, then {fetch_pc+4, rdata[63:32]}, in the same cycle. fetch_pc += 8.
  - If fetch_pc[2] = 1: push {fetch_pc, rdata[63:32]} only. fetch_pc += 4.
  - fetch_pc wraps modulo 2^CPU_WIDTH.
- Issue rule: the free-entries >= 2 check guarantees a push never overflows.
- Pop:
  - A pop occurs when o_ins_valid & i_ins_ready.
  - Push and pop in the same cycle are both honoured.
  - o_ins_valid = buffer not empty. o_ins and o_pc come combinationally from the head.
  - Earliest output is the cycle after rvalid.
- Redirect (highest priority):
  - Empties the buffer; o_ins_valid = 0 next cycle. A coincident pop is discarded.
  - fetch_pc = {i_redirect_pc[CPU_WIDTH-1:2],2'b00}.
  - In IDLE: the next cycle goes to REQ if space allows.
  - In REQ: the request is held until gnt, with drop = 1.
  - In WAIT: drop = 1.
  - With drop = 1, the next rvalid is discarded, drop clears, state goes to IDLE, and the new fetch then starts.
  - Redirect in the same cycle as rvalid: the beat is discarded and the redirect PC is taken.
  - A further redirect while drop = 1 overwrites fetch_pc only.
- Buffer: circular, with wrapping read/write pointers and a count. Full = count == FIFO_DEPTH. Overflow and underflow are impossible by construction; assert count <= FIFO_DEPTH.

Test Plan:
1. Reset, then release. Memory gives gnt immediately and rvalid 1 cycle later with rdata=64'h0000_0013_0010_0093 -> o_mem_addr=0x8000_0000. Head o_pc=0x8000_0000, o_ins=0x0010_0093. Next o_pc=0x8000_0004, o_ins=0x0000_0013. Next request address 0x8000_0008.
2. Redirect to 0x8000_0106 -> o_mem_addr=0x8000_0100. Only the upper word is pushed, with o_pc=0x8000_0104. Next address 0x8000_0108.
3. Hold i_ins_ready=0 with FIFO_DEPTH=4 -> 4 entries fill from 2 beats. o_mem_req stays 0 until 2 entries are popped, then resumes at 0x8000_0010.
4. Redirect to 0x8000_0200 in WAIT, rvalid 3 cycles later -> that beat is never output. The next request is 0x8000_0200, and the first o_pc is 0x8000_0200.
5. Redirect, pop and rvalid all in the same cycle -> buffer empty next cycle. No stale PC appears; the first output is the redirect-target instruction.
6. Assert i_rst in WAIT -> outputs return to reset values in the same cycle. After release, fetch restarts at 0x8000_0000, and a late rvalid from before reset is ignored.
